// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 32;
  localparam int DEPTH_D  = 64;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick: on a tie the port that did not win last time goes.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       any_req
);
  always_comb begin
    any_req = |req;
    winner  = P0;
    if (req[1] && !req[0])
      winner = P1;
    else if (req[1] && req[0])
      winner = (last_grant == P0) ? P1 : P0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port data memory between two requesters, one transaction
// per 3 cycles. Define MEM_ARB_ADDR_CHECK_EN to flag addresses >= DEPTH as errors.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH  = DEPTH_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [DATA_W-1:0] mem_dato,
  output logic [ADDR_W-1:0] mem_direccion,
  output logic              mem_sel,
  input  logic [DATA_W-1:0] mem_salida,
  output logic              busy
);
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  state_t                  state;
  logic                    win, last_grant, we_q, bad_q;
  logic [1:0]              gnt, rvalid, err;
  logic [1:0][DATA_W-1:0]  rdata;

  logic                    win_c, any_req, bad_c, sel_we;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;

  rr_arbiter2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .winner     (win_c),
    .any_req    (any_req)
  );

  assign sel_we    = win_c ? m1_we    : m0_we;
  assign sel_addr  = win_c ? m1_addr  : m0_addr;
  assign sel_wdata = win_c ? m1_wdata : m0_wdata;
  assign bad_c     = ADDR_CHK && (sel_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      win           <= P0;
      last_grant    <= P1;
      we_q          <= 1'b0;
      bad_q         <= 1'b0;
      gnt           <= '0;
      rvalid        <= '0;
      err           <= '0;
      rdata         <= '0;
      mem_sel       <= 1'b0;
      mem_dato      <= '0;
      mem_direccion <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          win         <= win_c;
          last_grant  <= win_c;
          we_q        <= sel_we;
          bad_q       <= bad_c;
          gnt[win_c]  <= 1'b1;
          // A rejected address leaves the memory bus untouched so reads stay stable.
          if (!bad_c) begin
            mem_direccion <= sel_addr;
            mem_dato      <= sel_wdata;
            mem_sel       <= sel_we;
          end
          state <= ACCESS;
        end
        ACCESS: begin
          gnt         <= '0;
          mem_sel     <= 1'b0;
          rdata[win]  <= (we_q || bad_q) ? '0 : mem_salida;
          rvalid[win] <= 1'b1;
          err[win]    <= bad_q;
          state       <= RESP;
        end
        RESP: begin
          rvalid <= '0;
          err    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
endmodule
